// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - memory-mapped bank of event counters with atomic low/high reads
module perf_counter_bank #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt_inc,
  input  logic               rd_en,
  input  logic [4:0]         rd_addr,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  output logic               overflow_irq
);

  localparam int HI_W = CNT_W - 32;

  logic               ctrl_enable;
  logic               ctrl_freeze;
  logic               ctrl_irq_en;
  logic [NUM_EVT-1:0] ovf;
  logic [NUM_EVT-1:0] mask;
  logic [CNT_W-1:0]   cnt [NUM_EVT];
  logic [HI_W-1:0]    shadow;

  logic               wr_ctrl;
  logic               clear_all;
  logic               wr_ovf;
  logic               wr_mask;
  logic [NUM_EVT-1:0] pl_lo;
  logic [NUM_EVT-1:0] pl_hi;
  logic [NUM_EVT-1:0] inc;
  logic [NUM_EVT-1:0] wrap;
  logic [31:0]        rd_mux;
  logic               shadow_cap;
  logic [HI_W-1:0]    shadow_nxt;

  // Write decode plus per-channel increment and wrap detection (uses current CTRL)
  always_comb begin
    wr_ctrl   = wr_en && (wr_addr == 5'h00);
    clear_all = wr_ctrl && wr_data[2];
    wr_ovf    = wr_en && (wr_addr == 5'h01);
    wr_mask   = wr_en && (wr_addr == 5'h02);
    pl_lo     = '0;
    pl_hi     = '0;
    inc       = '0;
    wrap      = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      pl_lo[i] = wr_en && (wr_addr == 5'(16 + 2 * i));
      pl_hi[i] = wr_en && (wr_addr == 5'(17 + 2 * i));
      inc[i]   = ctrl_enable && !ctrl_freeze && mask[i] && evt_inc[i];
      wrap[i]  = inc[i] && (cnt[i] == '1);
    end
  end

  // Read mux over pre-edge state; a low-word read also nominates the high bits for the shadow
  always_comb begin
    rd_mux     = '0;
    shadow_cap = 1'b0;
    shadow_nxt = shadow;
    if (rd_addr == 5'h00) begin
      rd_mux[3:0] = {ctrl_irq_en, 1'b0, ctrl_freeze, ctrl_enable};
    end else if (rd_addr == 5'h01) begin
      rd_mux[NUM_EVT-1:0] = ovf;
    end else if (rd_addr == 5'h02) begin
      rd_mux[NUM_EVT-1:0] = mask;
    end
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_addr == 5'(16 + 2 * i)) begin
        rd_mux     = cnt[i][31:0];
        shadow_cap = 1'b1;
        shadow_nxt = cnt[i][CNT_W-1:32];
      end
      if (rd_addr == 5'(17 + 2 * i)) begin
        rd_mux[HI_W-1:0] = shadow;
      end
    end
  end

  // Control and mask registers; clear_all does not suppress the CTRL bit updates
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_enable <= 1'b1;
      ctrl_freeze <= 1'b0;
      ctrl_irq_en <= 1'b0;
      mask        <= '1;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= wr_data[0];
        ctrl_freeze <= wr_data[1];
        ctrl_irq_en <= wr_data[3];
      end
      if (wr_mask) begin
        mask <= wr_data[NUM_EVT-1:0];
      end
    end
  end

  // Sticky overflow flags: a wrap on the same edge as a W1C keeps the flag set
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~(wr_data[NUM_EVT-1:0] & {NUM_EVT{wr_ovf}})) | wrap;
    end
  end

  // Counters: clear_all, then preload (drops that edge's increment), then increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rst || clear_all) begin
        cnt[i] <= '0;
      end else if (pl_lo[i]) begin
        cnt[i][31:0] <= wr_data;
      end else if (pl_hi[i]) begin
        cnt[i][CNT_W-1:32] <= wr_data[HI_W-1:0];
      end else if (inc[i]) begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Shadow of the high bits captured at each low-word read
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      shadow <= '0;
    end else if (rd_en && shadow_cap) begin
      shadow <= shadow_nxt;
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

  assign overflow_irq = ctrl_irq_en && |(ovf & mask);

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed and random checks against a behavioural model
module tb_perf_counter_bank;

  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 48;
  localparam longint unsigned MAXV = (64'd1 << CNT_W) - 64'd1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_EVT-1:0] evt_inc;
  logic               rd_en;
  logic [4:0]         rd_addr;
  logic [31:0]        rd_data;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [31:0]        wr_data;
  logic               overflow_irq;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  longint unsigned    m_cnt [NUM_EVT];
  longint unsigned    m_shadow;
  logic [NUM_EVT-1:0] m_ovf;
  logic [NUM_EVT-1:0] m_mask;
  logic               m_en, m_frz, m_irqen;
  logic [31:0]        m_rd;
  longint unsigned    snap [NUM_EVT];
  logic [31:0]        v;

  perf_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .evt_inc(evt_inc),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .overflow_irq(overflow_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int ch;
    ch = (int'(a) - 16) / 2;
    if (a == 5'd0) return {28'd0, m_irqen, 1'b0, m_frz, m_en};
    if (a == 5'd1) return 32'(m_ovf);
    if (a == 5'd2) return 32'(m_mask);
    if (a >= 5'd16 && ch < NUM_EVT) begin
      if (a[0] == 1'b0) return 32'(m_cnt[ch] % (64'd1 << 32));
      return 32'(m_shadow);
    end
    return 32'd0;
  endfunction

  // advance the model by one edge from the current inputs, clock the DUT, compare
  task automatic tick();
    logic [NUM_EVT-1:0] set_v;
    logic [NUM_EVT-1:0] w1c;
    longint unsigned    new_shadow;
    logic               clr, lo, hi, counting;
    int                 ch;
    if (rst) begin
      m_en = 1'b1; m_frz = 1'b0; m_irqen = 1'b0;
      m_mask = '1; m_ovf = '0; m_shadow = 0; m_rd = '0;
      for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = 0;
    end else begin
      new_shadow = m_shadow;
      if (rd_en) begin
        m_rd = model_read(rd_addr);
        ch = (int'(rd_addr) - 16) / 2;
        if (rd_addr >= 5'd16 && rd_addr[0] == 1'b0 && ch < NUM_EVT)
          new_shadow = m_cnt[ch] >> 32;
      end
      clr   = wr_en && wr_addr == 5'd0 && wr_data[2];
      w1c   = (wr_en && wr_addr == 5'd1) ? wr_data[NUM_EVT-1:0] : '0;
      set_v = '0;
      for (int i = 0; i < NUM_EVT; i++) begin
        lo = wr_en && int'(wr_addr) == 16 + 2 * i;
        hi = wr_en && int'(wr_addr) == 17 + 2 * i;
        counting = m_en && !m_frz && m_mask[i] && evt_inc[i];
        if (clr) m_cnt[i] = 0;
        else if (lo) m_cnt[i] = (m_cnt[i] >> 32 << 32) + 64'(wr_data);
        else if (hi) m_cnt[i] = ((64'(wr_data) % (64'd1 << (CNT_W - 32))) << 32) + (m_cnt[i] % (64'd1 << 32));
        else if (counting) begin
          if (m_cnt[i] == MAXV) begin
            m_cnt[i] = 0;
            set_v[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      m_ovf    = clr ? '0 : ((m_ovf & ~w1c) | set_v);
      m_shadow = clr ? 0 : new_shadow;
      if (wr_en && wr_addr == 5'd0) begin
        m_en = wr_data[0]; m_frz = wr_data[1]; m_irqen = wr_data[3];
      end
      if (wr_en && wr_addr == 5'd2) m_mask = wr_data[NUM_EVT-1:0];
    end
    @(posedge clk);
    #1;
    check("rd_data", rd_data, m_rd);
    check("irq", overflow_irq, m_irqen && |(m_ovf & m_mask));
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    val = rd_data;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; evt_inc = '0; rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    tick(); tick();
    check("reset_rd_data", rd_data, 0);
    check("reset_irq", overflow_irq, 0);
    rst = 1'b0;
    rd(5'h00, v); check("reset_ctrl", v, 32'h1);
    rd(5'h02, v); check("reset_mask", v, 32'hF);
    rd(5'h01, v); check("reset_ovf", v, 0);

    // 100 events on channel 0
    evt_inc = 4'b0001;
    repeat (100) tick();
    evt_inc = '0;
    rd(5'h10, v); check("c0_lo_100", v, 100);
    rd(5'h11, v); check("c0_hi", v, 0);
    for (int i = 1; i < NUM_EVT; i++) begin
      rd(5'(16 + 2 * i), v); check("other_lo_zero", v, 0);
    end

    // wrap on channel 1 with interrupt
    wr(5'h13, 32'hFFFF);
    wr(5'h12, 32'hFFFF_FFFF);
    wr(5'h00, 32'h9);
    evt_inc = 4'b0010;
    tick();
    evt_inc = '0;
    check("irq_rise", overflow_irq, 1);
    rd(5'h12, v); check("c1_lo_wrap", v, 0);
    rd(5'h13, v); check("c1_hi_wrap", v, 0);
    rd(5'h01, v); check("ovf_c1", v, 32'h2);
    wr(5'h01, 32'h2);
    check("irq_fall", overflow_irq, 0);

    // atomic low/high pair while channel 2 carries into the high word
    evt_inc = 4'b0100;
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h15, 32'h0);
    rd(5'h14, v); check("c2_lo_pre_carry", v, 32'hFFFF_FFFF);
    tick(); tick();
    rd(5'h15, v); check("c2_hi_shadow", v, 0);
    evt_inc = '0;
    rd(5'h14, v);
    rd(5'h15, v); check("c2_hi_live", v, 1);

    // freeze, then mask 0x5
    wr(5'h00, 32'h3);
    for (int i = 0; i < NUM_EVT; i++) snap[i] = m_cnt[i];
    evt_inc = '1;
    repeat (10) tick();
    evt_inc = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      rd(5'(16 + 2 * i), v); check("frozen", v, 32'(snap[i]));
    end
    wr(5'h00, 32'h1);
    wr(5'h02, 32'h5);
    for (int i = 0; i < NUM_EVT; i++) snap[i] = m_cnt[i];
    evt_inc = '1;
    repeat (10) tick();
    evt_inc = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      rd(5'(16 + 2 * i), v);
      check("masked", v, (i % 2 == 0) ? 32'(snap[i] + 10) : 32'(snap[i]));
    end

    // preload beats increment in the same cycle
    evt_inc = 4'b0001;
    wr(5'h10, 32'h10);
    evt_inc = '0;
    rd(5'h10, v); check("preload_wins", v, 32'h10);

    // W1C coincident with a wrap on channel 3 (unmask it first)
    wr(5'h02, 32'hF);
    wr(5'h16, 32'hFFFF_FFFF);
    wr(5'h17, 32'hFFFF);
    evt_inc = 4'b1000;
    tick();
    evt_inc = '0;
    wr(5'h16, 32'hFFFF_FFFF);
    wr(5'h17, 32'hFFFF);
    evt_inc = 4'b1000;
    wr(5'h01, 32'h8);
    evt_inc = '0;
    rd(5'h01, v); check("ovf_set_wins", v[3], 1);

    // clear_all while counting
    wr(5'h02, 32'h5);
    evt_inc = '1;
    wr(5'h00, 32'h5);
    evt_inc = '0;
    for (int i = 0; i < 2 * NUM_EVT; i++) begin
      rd(5'(16 + i), v); check("clear_cnt", v, 0);
    end
    rd(5'h01, v); check("clear_ovf", v, 0);
    rd(5'h02, v); check("clear_keeps_mask", v, 32'h5);
    rd(5'h00, v); check("clear_ctrl", v, 32'h1);

    // reset with strobes active
    evt_inc = '1;
    repeat (5) tick();
    rst = 1'b1; rd_en = 1'b1; rd_addr = 5'h10;
    wr_en = 1'b1; wr_addr = 5'h10; wr_data = 32'h1234;
    tick();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; evt_inc = '0;
    check("rst_rd_data", rd_data, 0);
    rd(5'h10, v); check("rst_cnt0", v, 0);
    rd(5'h00, v); check("rst_ctrl", v, 32'h1);
    rd(5'h02, v); check("rst_mask", v, 32'hF);

    // random traffic against the model
    repeat (400) begin
      evt_inc = NUM_EVT'($urandom);
      rd_en   = ($urandom_range(0, 2) == 0);
      rd_addr = 5'($urandom);
      wr_en   = ($urandom_range(0, 6) == 0);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      if (wr_addr == 5'd0 && $urandom_range(0, 3) != 0) wr_data[2] = 1'b0;
      tick();
    end
    rd_en = 1'b0; wr_en = 1'b0; evt_inc = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of memory-mapped event counters: the successor to the fixed cycle/instruction counter block. It provides NUM_EVT independent CNT_W-bit counters with per-channel enable, freeze, preload, sticky overflow flags and an overflow interrupt. All of this sits behind a 32-bit word-addressed read/write port in the CPU's MMIO decode. The core drives `evt_inc` from its pipeline events (cycle, retired instruction, stall, branch mispredict, ...), and software reads 64-bit-style values as atomic low/high pairs.

## Interface
- NUM_EVT, 4, number of counter channels, legal range 1..8
- CNT_W, 48, counter width in bits, legal range 33..64
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- evt_inc  in  NUM_EVT  per-channel increment request, sampled each cycle
- rd_en  in  1  read strobe
- rd_addr  in  5  word address of read
- rd_data  out  32  registered read data
- wr_en  in  1  write strobe
- wr_addr  in  5  word address of write
- wr_data  in  32  write data
- overflow_irq  out  1  level interrupt: CTRL.irq_en AND any unmasked sticky overflow

## Operation
- Register map (word addresses):
  - 0x00 CTRL: bit0 enable, bit1 freeze, bit3 irq_en. Bit2 is write-only clear_all and always reads 0.
  - 0x01 OVF: bits[NUM_EVT-1:0] sticky overflow flags; write-1-to-clear.
  - 0x02 MASK: bits[NUM_EVT-1:0] per-channel enable.
  - 0x10+2i: counter i bits[31:0].
  - 0x11+2i: counter i bits[CNT_W-1:32], zero-extended.
  - Any unmapped address, or a channel i >= NUM_EVT, reads 0 and ignores writes.
- Reset values:
  - CTRL: enable=1, freeze=0, irq_en=0.
  - MASK: all ones.
  - OVF, all counters, shadow register, rd_data: 0.
  - overflow_irq: 0.
- Counting:
  - Counter i increments by 1 when enable & !freeze & MASK[i] & evt_inc[i].
  - At all-ones it wraps to 0 and sets OVF[i] in the same edge.
- Atomic 64-bit read:
  - A read of any counter low word also captures that counter's high bits into a single shadow register.
  - A read of any counter high word returns the shadow register, not the live value.
  - Software reads low then high.
- Preload:
  - A write to a low word loads bits[31:0] of that counter.
  - A write to a high word loads bits[CNT_W-1:32]; excess wr_data bits are ignored.
  - The counter's other half is unchanged.
- clear_all (CTRL write with bit2=1) zeroes every counter, the shadow register and OVF. Bits 0, 1 and 3 of the same write still update CTRL.
- Priority within one cycle, highest first:
  1. rst.
  2. clear_all.
  3. Counter preload write. The write wins; that cycle's increment is lost.
  4. Increment.
- OVF set vs. W1C in the same cycle: set wins.
- Read and write may occur in the same cycle, including to the same address. The read returns the pre-write value.

## Timing
- Read latency is 1 cycle. rd_data is valid the cycle after rd_en and holds until the next rd_en or rst.
- A read returns counter and OVF state as of the cycle rd_en is asserted, i.e. before that edge's increment or update.
- A write takes effect at the rising edge where wr_en=1. The first possible increment after a preload happens on the following edge.
- overflow_irq is combinational from registered CTRL.irq_en and OVF only. It asserts the cycle after the wrapping edge and deasserts the cycle after the W1C or clear_all edge.
- Wrap: counter = 2^CNT_W-1 plus increment at edge N gives counter = 0 and OVF[i] = 1 after edge N.
- Reset mid-operation: rst at edge N returns all state to reset values after edge N, regardless of simultaneous rd_en, wr_en or evt_inc. rd_data is 0 in the following cycle.
- Freeze or enable changes apply from the edge after the CTRL write. Increments at the writing edge itself use the old CTRL.

## Test plan
- Reset, then evt_inc=4'b0001 for 100 cycles. Read 0x10 gives 100 (±0 versus the bench's own count); read 0x11 gives 0; all other channels read 0.
- Preload counter 1 with high=0xFFFF, low=0xFFFFFFFF (CNT_W=48), CTRL.irq_en=1, one evt_inc[1] pulse.
  - Counter 1 reads 0/0 and OVF reads 0x2.
  - overflow_irq rises the cycle after the wrap.
  - Writing OVF=0x2 drops the irq the cycle after the write.
- Preload counter 2 low=0xFFFFFFFF, high=0x0, evt_inc[2] held high.
  - Read low, then high 3 cycles later: the pair is consistent, i.e. the high value equals the shadow captured at the low read.
  - It is not the live high (0x1).
- CTRL freeze=1 for 10 cycles with all evt_inc high: counters unchanged. After MASK=0x5, only channels 0 and 2 advance.
- Same cycle: counter 0 preload 0x10 and evt_inc[0]=1: counter reads 0x10. Separately, OVF W1C coincident with a wrap: OVF bit stays 1.
- clear_all while counting, and rst asserted with wr_en/rd_en active: all counters, OVF and rd_data return to 0; CTRL/MASK return to reset values only on rst.
